// File: rtl/cnt_digit_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cnt_digit_gen : prescaled, cascadable up/down modulo digit counter
// Rev 1.0
// ---------------------------------------------------------------------------
module cnt_digit_gen #(
   parameter int WIDTH    = 4,
   parameter int PRESCALE = 36000,
   parameter int SRC      = 0
) (
   input  logic             in_clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up_dn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic [WIDTH-1:0] lim,
   input  logic             carry_in,
   output logic [WIDTH-1:0] q,
   output logic             co,
   output logic             tick
);

   localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   logic             step;
   logic [WIDTH-1:0] next_q;
   logic             next_co;
   logic [WIDTH-1:0] load_q;

   generate
      if (SRC == 0) begin : g_prescaler
         localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

         logic [PRE_W-1:0] pre_cnt;
         logic             pre_wrap;
         logic             unused_carry_in;

         assign unused_carry_in = carry_in;
         assign pre_wrap        = en && (pre_cnt == PRE_LAST);
         assign step            = pre_wrap;

         // A load restarts the prescale phase so the next step is a full period away.
         always_ff @(posedge in_clk or negedge rst) begin
            if (!rst) begin
               pre_cnt <= '0;
               tick    <= 1'b0;
            end else if (load) begin
               pre_cnt <= '0;
               tick    <= 1'b0;
            end else if (pre_wrap) begin
               pre_cnt <= '0;
               tick    <= 1'b1;
            end else begin
               if (en) begin
                  pre_cnt <= pre_cnt + PRE_W'(1);
               end
               tick <= 1'b0;
            end
         end
      end else begin : g_external
         assign step = en & carry_in;
         assign tick = 1'b0;
      end
   endgenerate

   assign load_q = (load_val > lim) ? lim : load_val;

   // q > lim can only arise after lim is lowered at runtime; both directions clamp it.
   always_comb begin
      next_q  = q;
      next_co = 1'b0;
      if (up_dn) begin
         if (q >= lim) begin
            next_q  = '0;
            next_co = 1'b1;
         end else begin
            next_q = q + WIDTH'(1);
         end
      end else begin
         if (q == '0) begin
            next_q  = lim;
            next_co = 1'b1;
         end else if (q > lim) begin
            next_q = lim;
         end else begin
            next_q = q - WIDTH'(1);
         end
      end
   end

   always_ff @(posedge in_clk or negedge rst) begin
      if (!rst) begin
         q  <= '0;
         co <= 1'b0;
      end else if (load) begin
         q  <= load_q;
         co <= 1'b0;
      end else if (step) begin
         q  <= next_q;
         co <= next_co;
      end else begin
         co <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_cnt_digit_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_cnt_digit_gen : directed + randomized bench with integer reference model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_cnt_digit_gen;

   localparam int P_MAIN = 4;
   localparam int P_A    = 2;
   localparam int LIM_A  = 9;
   localparam int LIM_B  = 5;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0, up_dn = 1'b1, load = 1'b0;
   logic [3:0] load_val = 4'd0, lim = 4'd3;
   logic [3:0] q;
   logic       co, tick;

   logic       c_en = 1'b0;
   logic [3:0] a_q, b_q;
   logic       a_co, a_tick, b_co, b_tick;

   int tests = 0;
   int fails = 0;

   // reference model state (plain integers)
   int m_pre, m_q, m_co, m_tick;
   int ma_pre, ma_q, ma_co, ma_tick;
   int mb_q, mb_co;

   always #5 clk = ~clk;

   cnt_digit_gen #(.WIDTH(4), .PRESCALE(P_MAIN), .SRC(0)) dut (
      .in_clk(clk), .rst(rst_n), .en(en), .up_dn(up_dn), .load(load),
      .load_val(load_val), .lim(lim), .carry_in(1'b0),
      .q(q), .co(co), .tick(tick)
   );

   cnt_digit_gen #(.WIDTH(4), .PRESCALE(P_A), .SRC(0)) stage_a (
      .in_clk(clk), .rst(rst_n), .en(c_en), .up_dn(1'b1), .load(1'b0),
      .load_val(4'd0), .lim(4'd9), .carry_in(1'b0),
      .q(a_q), .co(a_co), .tick(a_tick)
   );

   cnt_digit_gen #(.WIDTH(4), .PRESCALE(2), .SRC(1)) stage_b (
      .in_clk(clk), .rst(rst_n), .en(c_en), .up_dn(1'b1), .load(1'b0),
      .load_val(4'd0), .lim(4'd5), .carry_in(a_co),
      .q(b_q), .co(b_co), .tick(b_tick)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   // One counting step on a digit whose range is 0..lm.
   task automatic digit_rule(input int qv, input int lm, input bit up, output int nq, output int nco);
      nco = 0;
      if (up) begin
         if (qv >= lm) begin nq = 0; nco = 1; end
         else nq = qv + 1;
      end else begin
         if (qv == 0)      begin nq = lm; nco = 1; end
         else if (qv > lm) nq = lm;
         else              nq = qv - 1;
      end
   endtask

   task automatic model_reset();
      m_pre = 0;  m_q = 0;  m_co = 0;  m_tick = 0;
      ma_pre = 0; ma_q = 0; ma_co = 0; ma_tick = 0;
      mb_q = 0;   mb_co = 0;
   endtask

   task automatic model_edge();
      bit b_step;
      int s;
      b_step = c_en && (ma_co != 0);
      if (load) begin
         m_q    = (int'(load_val) > int'(lim)) ? int'(lim) : int'(load_val);
         m_pre  = 0;
         m_co   = 0;
         m_tick = 0;
      end else if (en) begin
         s      = (m_pre == P_MAIN - 1) ? 1 : 0;
         m_pre  = s ? 0 : m_pre + 1;
         m_tick = s;
         if (s) digit_rule(m_q, int'(lim), up_dn, m_q, m_co);
         else   m_co = 0;
      end else begin
         m_co = 0;
         m_tick = 0;
      end
      if (c_en) begin
         s       = (ma_pre == P_A - 1) ? 1 : 0;
         ma_pre  = s ? 0 : ma_pre + 1;
         ma_tick = s;
         if (s) digit_rule(ma_q, LIM_A, 1'b1, ma_q, ma_co);
         else   ma_co = 0;
      end else begin
         ma_co = 0;
         ma_tick = 0;
      end
      if (b_step) digit_rule(mb_q, LIM_B, 1'b1, mb_q, mb_co);
      else        mb_co = 0;
   endtask

   task automatic check_all();
      check("q", q, m_q);
      check("co", co, m_co);
      check("tick", tick, m_tick);
      check("a_q", a_q, ma_q);
      check("a_co", a_co, ma_co);
      check("a_tick", a_tick, ma_tick);
      check("b_q", b_q, mb_q);
      check("b_co", b_co, mb_co);
      check("b_tick", b_tick, 0);
   endtask

   task automatic clk_step();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic async_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      model_reset();
      check("rst_q", q, 0);
      check("rst_co", co, 0);
      check("rst_tick", tick, 0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      model_reset();
      #12;
      check_all();
      rst_n = 1'b1;

      // basic up count, lim=3
      en = 1'b1; up_dn = 1'b1; lim = 4'd3;
      repeat (20) clk_step();

      // down count from 0 with lim=9
      load = 1'b1; load_val = 4'd0; lim = 4'd9; up_dn = 1'b0;
      clk_step();
      load = 1'b0;
      repeat (4) clk_step();
      check("down_wrap_q", q, 9);
      check("down_wrap_co", co, 1);
      repeat (4) clk_step();
      check("down_next_q", q, 8);
      check("down_next_co", co, 0);

      // load coincident with a step: clamp, no carry, prescale restarts
      lim = 4'd5; up_dn = 1'b1;
      for (int i = 0; i < 8 && m_pre != P_MAIN - 1; i++) clk_step();
      check("load_align", m_pre, P_MAIN - 1);
      load = 1'b1; load_val = 4'd7;
      clk_step();
      check("load_clamp_q", q, 5);
      check("load_clamp_co", co, 0);
      load = 1'b0;
      repeat (3) clk_step();
      check("load_hold_q", q, 5);
      clk_step();
      check("load_step_q", q, 0);
      check("load_step_co", co, 1);

      // enable hold mid-prescale
      repeat (2) clk_step();
      en = 1'b0;
      repeat (10) clk_step();
      en = 1'b1;
      repeat (6) clk_step();

      async_reset();

      // runtime lim lowered below q, up and down
      lim = 4'd9; load = 1'b1; load_val = 4'd8; up_dn = 1'b1;
      clk_step();
      load = 1'b0; lim = 4'd3;
      repeat (4) clk_step();
      check("limdn_up_q", q, 0);
      check("limdn_up_co", co, 1);
      lim = 4'd9; load = 1'b1; load_val = 4'd8; up_dn = 1'b0;
      clk_step();
      load = 1'b0; lim = 4'd3;
      repeat (4) clk_step();
      check("limdn_dn_q", q, 3);
      check("limdn_dn_co", co, 0);

      // lim=0: q pinned at 0, carry every step
      lim = 4'd0; up_dn = 1'b1;
      repeat (12) clk_step();

      // randomized traffic
      repeat (400) begin
         en       = ($urandom_range(0, 7) != 0);
         up_dn    = 1'($urandom);
         load     = ($urandom_range(0, 15) == 0);
         load_val = 4'($urandom);
         if ($urandom_range(0, 7) == 0) lim = 4'($urandom);
         clk_step();
      end
      load = 1'b0;
      en = 1'b0;

      // cascade A(co) -> B(carry_in)
      async_reset();
      c_en = 1'b1;
      repeat (20) clk_step();
      check("casc_a20_q", a_q, 0);
      check("casc_a20_co", a_co, 1);
      check("casc_b20_q", b_q, 0);
      clk_step();
      check("casc_b21_q", b_q, 1);
      check("casc_a21_q", a_q, 0);
      repeat (120) clk_step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
